// File: rtl/cpu_run_ctrl.sv
// Run/load controller for the pipelined RISC-V core: synchronizes the byte strobe and loads program memory.
// It sequences run/halt/step; optional cycle counter enabled by defining CYCLE_COUNT_EN.
module cpu_run_ctrl #(
    parameter int IMEM_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              strb_in,
    input  logic [1:0]        cmd,
    input  logic [7:0]        data_in,
    input  logic              halt_req,
    output logic              cpu_en,
    output logic              cpu_rst_n,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              load_done,
    output logic [2:0]        state_o,
    output logic [15:0]       cyc_cnt
);

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;
    localparam logic [1:0] CMD_STEP = 2'b11;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HALT = 3'd3,
        ST_STEP = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic [23:0]         r_word;
    logic [1:0]          r_byte_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_imem_we;
    logic [31:0]         r_imem_wdata;
    logic                r_load_done;
    logic                r_cpu_en;
    logic                r_cpu_rst_n;

    state_t              w_state_nxt;
    logic                w_evt;
    logic                w_last_write;
    logic                w_load_entry;
    logic                w_byte_accept;
    logic                w_word_done;

    assign w_evt         = r_sync2 & ~r_sync3;
    assign w_last_write  = r_imem_we && (r_addr == LAST_ADDR);
    assign w_load_entry  = (w_state_nxt == ST_LOAD) && (r_state != ST_LOAD);
    assign w_byte_accept = w_evt && (cmd == CMD_LOAD) && (r_state == ST_LOAD) && (w_state_nxt == ST_LOAD);
    assign w_word_done   = w_byte_accept && (r_byte_cnt == 2'd3);

    // Next-state decode; halt_req in RUN wins over any same-cycle event.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_evt) begin
                    case (cmd)
                        CMD_LOAD: w_state_nxt = ST_LOAD;
                        CMD_RUN:  w_state_nxt = ST_RUN;
                        CMD_STEP: w_state_nxt = ST_STEP;
                        default:  w_state_nxt = r_state;
                    endcase
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_LOAD: begin
                if (w_last_write) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_evt && (cmd == CMD_STOP)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (w_evt) begin
                    case (cmd)
                        CMD_STOP: w_state_nxt = ST_HALT;
                        CMD_LOAD: w_state_nxt = ST_LOAD;
                        default:  w_state_nxt = r_state;
                    endcase
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_HALT: begin
                if (w_evt) begin
                    case (cmd)
                        CMD_RUN:  w_state_nxt = ST_RUN;
                        CMD_STEP: w_state_nxt = ST_STEP;
                        CMD_LOAD: w_state_nxt = ST_LOAD;
                        default:  w_state_nxt = r_state;
                    endcase
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_STEP: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, synchronizer and load datapath; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_word       <= 24'd0;
            r_byte_cnt   <= 2'd0;
            r_addr       <= '0;
            r_imem_we    <= 1'b0;
            r_imem_wdata <= 32'd0;
            r_load_done  <= 1'b0;
            r_cpu_en     <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
        end else if (ena) begin
            r_sync1     <= strb_in;
            r_sync2     <= r_sync1;
            r_sync3     <= r_sync2;
            r_state     <= w_state_nxt;
            r_cpu_en    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP);
            r_cpu_rst_n <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_LOAD);
            r_imem_we   <= w_word_done;
            if (w_word_done) begin
                r_imem_wdata <= {data_in, r_word};
            end
            if (w_byte_accept) begin
                r_word <= {data_in, r_word[23:8]};
            end
            if ((w_state_nxt != ST_LOAD) || w_load_entry) begin
                r_byte_cnt <= 2'd0;
            end else if (w_byte_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            // The address advances only after the write cycle; the last word wraps it to zero.
            if (w_load_entry) begin
                r_addr      <= '0;
                r_load_done <= 1'b0;
            end else if (r_imem_we) begin
                r_addr <= r_addr + ADDR_ONE;
                if (w_last_write) begin
                    r_load_done <= 1'b1;
                end
            end
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [15:0] r_cyc_cnt;

    // Saturating count of enabled core cycles, restarted by each new load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt <= 16'd0;
        end else if (ena) begin
            if (w_load_entry) begin
                r_cyc_cnt <= 16'd0;
            end else if (r_cpu_en && (r_cyc_cnt != 16'hFFFF)) begin
                r_cyc_cnt <= r_cyc_cnt + 16'd1;
            end
        end
    end

    assign cyc_cnt = r_cyc_cnt;
`else
    assign cyc_cnt = 16'd0;
`endif

    assign cpu_en     = r_cpu_en & ena;
    assign imem_we    = r_imem_we & ena;
    assign cpu_rst_n  = r_cpu_rst_n;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_imem_wdata;
    assign load_done  = r_load_done;
    assign state_o    = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: command table, timed corner sequences and a randomized run against a transaction model.
module tb_cpu_run_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_RUN  = 2;
    localparam int S_HALT = 3;

    localparam logic [1:0] C_STOP = 2'b00;
    localparam logic [1:0] C_LOAD = 2'b01;
    localparam logic [1:0] C_RUN  = 2'b10;
    localparam logic [1:0] C_STEP = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        strb_in;
    logic [1:0]  cmd;
    logic [7:0]  data_in;
    logic        halt_req;
    logic        cpu_en;
    logic        cpu_rst_n;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        load_done;
    logic [2:0]  state_o;
    logic [15:0] cyc_cnt;

    cpu_run_ctrl #(.IMEM_DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .strb_in(strb_in), .cmd(cmd),
        .data_in(data_in), .halt_req(halt_req), .cpu_en(cpu_en), .cpu_rst_n(cpu_rst_n),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .load_done(load_done), .state_o(state_o), .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Write/enable monitor sampled at the active edge, i.e. what the memory and core see.
    int          n_we = 0;
    int          n_en = 0;
    int          n_rst_hi = 0;
    int          n_wide = 0;
    logic        prev_we = 1'b0;
    logic [31:0] mem_seen [16];
    always @(posedge clk) begin
        if (imem_we) begin
            mem_seen[imem_addr] = imem_wdata;
            n_we++;
            if (prev_we) n_wide++;
        end
        prev_we = imem_we;
        if (cpu_en) n_en++;
        if (cpu_rst_n) n_rst_hi++;
    end

    typedef struct {
        logic [1:0] c;
        int         exp_state;
        logic       exp_en;
        logic       exp_rst_n;
    } vec_t;
    vec_t tbl [14];

    // Transaction-level reference model
    int          m_state;
    int          m_addr;
    logic        m_done;
    logic [7:0]  m_q [$];
    logic [31:0] m_mem [16];
    bit          m_wr [16];
    int          m_writes;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_evt(input logic [1:0] c, input logic [7:0] d);
        cmd = c;
        data_in = d;
        strb_in = 1'b1;
        tick(4);
        strb_in = 1'b0;
        tick(4);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " state_o"}, 32'(state_o), 32'd0);
        check({tag, " cpu_en"}, 32'(cpu_en), 32'd0);
        check({tag, " cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        check({tag, " imem_we"}, 32'(imem_we), 32'd0);
        check({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, " imem_wdata"}, imem_wdata, 32'd0);
        check({tag, " load_done"}, 32'(load_done), 32'd0);
        check({tag, " cyc_cnt"}, 32'(cyc_cnt), 32'd0);
    endtask

    task automatic model_enter_load();
        m_state = S_LOAD;
        m_addr = 0;
        m_done = 1'b0;
        m_q.delete();
    endtask

    task automatic model_evt(input logic [1:0] c, input logic [7:0] d);
        case (m_state)
            S_IDLE: begin
                if (c == C_LOAD) model_enter_load();
                else if (c == C_RUN) m_state = S_RUN;
                else if (c == C_STEP) m_state = S_HALT;
            end
            S_LOAD: begin
                if (c == C_LOAD) begin
                    m_q.push_back(d);
                    if (m_q.size() == 4) begin
                        m_mem[m_addr] = {m_q[3], m_q[2], m_q[1], m_q[0]};
                        m_wr[m_addr] = 1'b1;
                        m_writes++;
                        m_q.delete();
                        m_addr++;
                        if (m_addr == 16) begin
                            m_addr = 0;
                            m_done = 1'b1;
                            m_state = S_IDLE;
                        end
                    end
                end else if (c == C_STOP) begin
                    m_q.delete();
                    m_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (c == C_STOP) m_state = S_HALT;
                else if (c == C_LOAD) model_enter_load();
            end
            default: begin
                if (c == C_RUN) m_state = S_RUN;
                else if (c == C_STEP) m_state = S_HALT;
                else if (c == C_LOAD) model_enter_load();
            end
        endcase
    endtask

    initial begin
        int base_we;
        int base_en;
        int base_rst;
        int base_wide;
        logic [31:0] exp_cyc;

        rst_n = 1'b0; ena = 1'b1; strb_in = 1'b0; cmd = C_STOP; data_in = 8'd0; halt_req = 1'b0;
        tbl[0]  = '{C_STOP, S_IDLE, 1'b0, 1'b0};
        tbl[1]  = '{C_STEP, S_HALT, 1'b0, 1'b1};
        tbl[2]  = '{C_STOP, S_HALT, 1'b0, 1'b1};
        tbl[3]  = '{C_RUN,  S_RUN,  1'b1, 1'b1};
        tbl[4]  = '{C_STEP, S_RUN,  1'b1, 1'b1};
        tbl[5]  = '{C_RUN,  S_RUN,  1'b1, 1'b1};
        tbl[6]  = '{C_STOP, S_HALT, 1'b0, 1'b1};
        tbl[7]  = '{C_LOAD, S_LOAD, 1'b0, 1'b0};
        tbl[8]  = '{C_RUN,  S_LOAD, 1'b0, 1'b0};
        tbl[9]  = '{C_STEP, S_LOAD, 1'b0, 1'b0};
        tbl[10] = '{C_STOP, S_IDLE, 1'b0, 1'b0};
        tbl[11] = '{C_RUN,  S_RUN,  1'b1, 1'b1};
        tbl[12] = '{C_LOAD, S_LOAD, 1'b0, 1'b0};
        tbl[13] = '{C_STOP, S_IDLE, 1'b0, 1'b0};

        tick(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 14; i++) begin
            send_evt(tbl[i].c, 8'd0);
            check($sformatf("tbl%0d state", i), 32'(state_o), 32'(tbl[i].exp_state));
            check($sformatf("tbl%0d cpu_en", i), 32'(cpu_en), 32'(tbl[i].exp_en));
            check($sformatf("tbl%0d cpu_rst_n", i), 32'(cpu_rst_n), 32'(tbl[i].exp_rst_n));
        end

        // RUN from IDLE: takes effect two edges after the strobe is first sampled
        cmd = C_RUN; strb_in = 1'b1;
        tick(2);
        check("run E state", 32'(state_o), 32'(S_IDLE));
        check("run E cpu_en", 32'(cpu_en), 32'd0);
        tick(1);
        check("run E+1 cpu_en", 32'(cpu_en), 32'd1);
        check("run E+1 cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("run E+1 state", 32'(state_o), 32'(S_RUN));
        strb_in = 1'b0;
        tick(4);

        // halt_req in the same cycle as a STOP event
        cmd = C_STOP; strb_in = 1'b1;
        tick(2);
        halt_req = 1'b1;
        check("halt H cpu_en", 32'(cpu_en), 32'd1);
        tick(1);
        halt_req = 1'b0;
        check("halt H+1 cpu_en", 32'(cpu_en), 32'd0);
        check("halt H+1 state", 32'(state_o), 32'(S_HALT));
        tick(3);
        strb_in = 1'b0;
        tick(6);
        check("halt settled state", 32'(state_o), 32'(S_HALT));
        check("halt settled cpu_en", 32'(cpu_en), 32'd0);

        // Single steps: counter cleared by LOAD, then 1 + 3 steps
        send_evt(C_LOAD, 8'd0);
        send_evt(C_STOP, 8'd0);
        send_evt(C_STEP, 8'd0);
        check("step1 state", 32'(state_o), 32'(S_HALT));
        base_en = n_en;
        for (int i = 0; i < 3; i++) send_evt(C_STEP, 8'd0);
        check("step3 en cycles", 32'(n_en - base_en), 32'd3);
        check("step3 state", 32'(state_o), 32'(S_HALT));
`ifdef CYCLE_COUNT_EN
        exp_cyc = 32'd4;
`else
        exp_cyc = 32'd0;
`endif
        check("step cyc_cnt", 32'(cyc_cnt), exp_cyc);

        // Full 64-byte load
        send_evt(C_LOAD, 8'd0);
        base_we = n_we; base_rst = n_rst_hi; base_wide = n_wide;
        for (int b = 0; b < 63; b++) send_evt(C_LOAD, 8'(b));
        cmd = C_LOAD; data_in = 8'h3F; strb_in = 1'b1;
        tick(3);
        check("last E+1 imem_we", 32'(imem_we), 32'd1);
        check("last E+1 addr", 32'(imem_addr), 32'd15);
        check("last E+1 wdata", imem_wdata, 32'h3F3E3D3C);
        check("last E+1 state", 32'(state_o), 32'(S_LOAD));
        check("last E+1 load_done", 32'(load_done), 32'd0);
        tick(1);
        check("last E+2 imem_we", 32'(imem_we), 32'd0);
        check("last E+2 state", 32'(state_o), 32'(S_IDLE));
        check("last E+2 load_done", 32'(load_done), 32'd1);
        check("last E+2 addr", 32'(imem_addr), 32'd0);
        strb_in = 1'b0;
        tick(4);
        check("load we pulses", 32'(n_we - base_we), 32'd16);
        check("load we width", 32'(n_wide - base_wide), 32'd0);
        check("load word0", mem_seen[0], 32'h03020100);
        check("load word15", mem_seen[15], 32'h3F3E3D3C);
        check("load cpu_rst_n high cycles", 32'(n_rst_hi - base_rst), 32'd0);

        // One full word, then a partial word aborted by STOP
        send_evt(C_LOAD, 8'd0);
        base_we = n_we;
        send_evt(C_LOAD, 8'hAA); send_evt(C_LOAD, 8'hBB);
        send_evt(C_LOAD, 8'hCC); send_evt(C_LOAD, 8'hDD);
        send_evt(C_LOAD, 8'h55); send_evt(C_LOAD, 8'h66);
        send_evt(C_STOP, 8'd0);
        check("abort state", 32'(state_o), 32'(S_IDLE));
        check("abort addr", 32'(imem_addr), 32'd1);
        check("abort writes", 32'(n_we - base_we), 32'd1);
        check("abort word0", mem_seen[0], 32'hDDCCBBAA);
        check("abort load_done", 32'(load_done), 32'd0);
        send_evt(C_LOAD, 8'd0);
        check("reload addr", 32'(imem_addr), 32'd0);
        check("reload state", 32'(state_o), 32'(S_LOAD));
        send_evt(C_STOP, 8'd0);

        // Asynchronous reset after five load bytes
        send_evt(C_LOAD, 8'd0);
        for (int b = 0; b < 5; b++) send_evt(C_LOAD, 8'(8'h70 + b));
        check("pre-reset addr", 32'(imem_addr), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        send_evt(C_LOAD, 8'd0);
        check("post-reset state", 32'(state_o), 32'(S_LOAD));
        check("post-reset addr", 32'(imem_addr), 32'd0);
        check("post-reset load_done", 32'(load_done), 32'd0);
        send_evt(C_LOAD, 8'h11); send_evt(C_LOAD, 8'h22);
        send_evt(C_LOAD, 8'h33); send_evt(C_LOAD, 8'h44);
        check("post-reset word0", mem_seen[0], 32'h44332211);
        check("post-reset addr1", 32'(imem_addr), 32'd1);
        send_evt(C_STOP, 8'd0);

        // ena low: outputs forced low, a strobe is lost
        send_evt(C_RUN, 8'd0);
        ena = 1'b0;
        tick(1);
        check("ena0 cpu_en", 32'(cpu_en), 32'd0);
        check("ena0 state", 32'(state_o), 32'(S_RUN));
        send_evt(C_STOP, 8'd0);
        ena = 1'b1;
        tick(4);
        check("ena1 state", 32'(state_o), 32'(S_RUN));
        check("ena1 cpu_en", 32'(cpu_en), 32'd1);
        send_evt(C_STOP, 8'd0);

        // Randomized transactions against the model
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        m_state = S_IDLE; m_addr = 0; m_done = 1'b0; m_writes = 0; m_q.delete();
        for (int i = 0; i < 16; i++) begin m_mem[i] = 32'd0; m_wr[i] = 1'b0; end
        base_we = n_we;
        for (int t = 0; t < 150; t++) begin
            int r;
            logic [1:0] c;
            logic [7:0] d;
            r = $urandom_range(0, 99);
            if (r < 15) begin
                halt_req = 1'b1;
                tick(1);
                halt_req = 1'b0;
                tick(3);
                if (m_state == S_RUN) m_state = S_HALT;
            end else begin
                c = (r < 65) ? C_LOAD : 2'($urandom_range(0, 3));
                d = 8'($urandom_range(0, 255));
                send_evt(c, d);
                model_evt(c, d);
            end
            check($sformatf("rnd%0d state", t), 32'(state_o), 32'(m_state));
            check($sformatf("rnd%0d load_done", t), 32'(load_done), 32'(m_done));
            check($sformatf("rnd%0d addr", t), 32'(imem_addr), 32'(m_addr));
            check($sformatf("rnd%0d cpu_en", t), 32'(cpu_en), 32'(m_state == S_RUN));
            check($sformatf("rnd%0d cpu_rst_n", t), 32'(cpu_rst_n),
                  32'((m_state != S_IDLE) && (m_state != S_LOAD)));
        end
        check("rnd write count", 32'(n_we - base_we), 32'(m_writes));
        for (int i = 0; i < 16; i++) begin
            if (m_wr[i]) check($sformatf("rnd mem%0d", i), mem_seen[i], m_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
